// File: rtl/shift_pkg.sv
// Shared definitions for the shift pipeline: op encodings and op classification helpers.
package shift_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        SHIFT_SLL = 3'b000,
        SHIFT_SRL = 3'b001,
        SHIFT_SRA = 3'b010,
        SHIFT_ROL = 3'b011,
        SHIFT_ROR = 3'b100
    } shift_op_e;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= SHIFT_ROR;
    endfunction

    function automatic logic op_is_left(input logic [OP_W-1:0] op);
        return (op == SHIFT_SLL) || (op == SHIFT_ROL);
    endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Valid/ready request and response channels of the shift pipeline.
interface shift_pipe_if
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [OP_W-1:0]    in_op;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               out_illegal;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_illegal
    );

endinterface

// File: rtl/shift_pipe_stage.sv
// One log-shifter stage of fixed distance DIST, optionally followed by a valid/ready register slice.
module shift_pipe_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned DIST  = 16,
    parameter bit          REG   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    input  logic [OP_W-1:0]            in_op,
    input  logic                       in_fill,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       in_illegal,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH)-1:0]   out_shamt,
    output logic [OP_W-1:0]            out_op,
    output logic                       out_fill,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_illegal
);

    localparam int unsigned SEL = $clog2(DIST);

    logic [DIST-1:0]  fill_bits;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] stage_data;

    // Rotates are plain shifts whose vacated bits are refilled from the bits shifted out.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        fill_bits = '0;
        case (in_op)
            SHIFT_SRA: fill_bits = {DIST{in_fill}};
            SHIFT_ROL: fill_bits = in_data[WIDTH-1 -: DIST];
            SHIFT_ROR: fill_bits = in_data[DIST-1:0];
            default:   fill_bits = '0;
        endcase

        if (op_is_left(in_op)) begin
            shifted = {in_data[WIDTH-DIST-1:0], fill_bits};
        end else begin
            shifted = {fill_bits, in_data[WIDTH-1:DIST]};
        end

        stage_data = (in_shamt[SEL] && !in_illegal) ? shifted : in_data;
    end

    if (REG) begin : g_slice
        logic                     valid_q,   valid_d;
        logic [WIDTH-1:0]         data_q,    data_d;
        logic [$clog2(WIDTH)-1:0] shamt_q,   shamt_d;
        logic [OP_W-1:0]          op_q,      op_d;
        logic                     fill_q,    fill_d;
        logic [TAG_W-1:0]         tag_q,     tag_d;
        logic                     illegal_q, illegal_d;
        logic                     load;

        // Loads when empty or when the downstream slice takes the current item this cycle.
        assign in_ready = !valid_q || out_ready;

        always_comb begin
            load      = in_valid && in_ready;
            valid_d   = in_ready ? in_valid : valid_q;
            data_d    = load ? stage_data : data_q;
            shamt_d   = load ? in_shamt   : shamt_q;
            op_d      = load ? in_op      : op_q;
            fill_d    = load ? in_fill    : fill_q;
            tag_d     = load ? in_tag     : tag_q;
            illegal_d = load ? in_illegal : illegal_q;
        end

        // NOTE: payload registers are reset too, so the output bus reads all-zero after reset.
        always_ff @(posedge clk) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (rst) begin
                valid_q   <= 1'b0;
                data_q    <= '0;
                shamt_q   <= '0;
                op_q      <= '0;
                fill_q    <= 1'b0;
                tag_q     <= '0;
                illegal_q <= 1'b0;
            end else begin
                valid_q   <= valid_d;
                data_q    <= data_d;
                shamt_q   <= shamt_d;
                op_q      <= op_d;
                fill_q    <= fill_d;
                tag_q     <= tag_d;
                illegal_q <= illegal_d;
            end
        end

        assign out_valid   = valid_q;
        assign out_data    = data_q;
        assign out_shamt   = shamt_q;
        assign out_op      = op_q;
        assign out_fill    = fill_q;
        assign out_tag     = tag_q;
        assign out_illegal = illegal_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign in_ready    = out_ready;
        assign out_valid   = in_valid;
        assign out_data    = stage_data;
        assign out_shamt   = in_shamt;
        assign out_op      = in_op;
        assign out_fill    = in_fill;
        assign out_tag     = in_tag;
        assign out_illegal = in_illegal;
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SHAMT_W log stages (largest distance first), registered output,
// optional intermediate slices selected by PIPE_MASK, tag and op riding along with the data.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter logic [7:0]  PIPE_MASK = 8'b0000_0100,
    parameter int unsigned TAG_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    shift_pipe_if.slave bus
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam bit SLICE = (k == SHAMT_W - 1) || PIPE_MASK[k];

        logic               up_valid,   dn_valid;
        logic               up_ready,   dn_ready;
        logic [WIDTH-1:0]   up_data,    dn_data;
        logic [SHAMT_W-1:0] up_shamt,   dn_shamt;
        logic [OP_W-1:0]    up_op,      dn_op;
        logic               up_fill,    dn_fill;
        logic [TAG_W-1:0]   up_tag,     dn_tag;
        logic               up_illegal, dn_illegal;

        if (k == 0) begin : g_head
            // The SRA fill bit is captured once here so later stages never see a shifted MSB.
            assign up_valid   = bus.in_valid & ~rst;
            assign up_data    = bus.in_data;
            assign up_shamt   = bus.in_shamt;
            assign up_op      = bus.in_op;
            assign up_fill    = bus.in_data[WIDTH-1];
            assign up_tag     = bus.in_tag;
            assign up_illegal = ~op_is_legal(bus.in_op);
        end else begin : g_link
            assign up_valid   = g_stage[k-1].dn_valid;
            assign up_data    = g_stage[k-1].dn_data;
            assign up_shamt   = g_stage[k-1].dn_shamt;
            assign up_op      = g_stage[k-1].dn_op;
            assign up_fill    = g_stage[k-1].dn_fill;
            assign up_tag     = g_stage[k-1].dn_tag;
            assign up_illegal = g_stage[k-1].dn_illegal;
        end

        if (k == SHAMT_W - 1) begin : g_tail
            logic unused_ctl;
            assign dn_ready   = bus.out_ready;
            assign unused_ctl = ^{dn_shamt, dn_op, dn_fill};
        end else begin : g_mid
            assign dn_ready = g_stage[k+1].up_ready;
        end

        shift_pipe_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .DIST  (WIDTH >> (k + 1)),
            .REG   (SLICE)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (up_valid),
            .in_ready    (up_ready),
            .in_data     (up_data),
            .in_shamt    (up_shamt),
            .in_op       (up_op),
            .in_fill     (up_fill),
            .in_tag      (up_tag),
            .in_illegal  (up_illegal),
            .out_valid   (dn_valid),
            .out_ready   (dn_ready),
            .out_data    (dn_data),
            .out_shamt   (dn_shamt),
            .out_op      (dn_op),
            .out_fill    (dn_fill),
            .out_tag     (dn_tag),
            .out_illegal (dn_illegal)
        );
    end

    assign bus.in_ready    = g_stage[0].up_ready & ~rst;
    assign bus.out_valid   = g_stage[SHAMT_W-1].dn_valid;
    assign bus.out_data    = g_stage[SHAMT_W-1].dn_data;
    assign bus.out_tag     = g_stage[SHAMT_W-1].dn_tag;
    assign bus.out_illegal = g_stage[SHAMT_W-1].dn_illegal;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench: directed cases on the default configuration plus a randomized
// scoreboard run on four width/slice configurations against a plain-arithmetic model.
module tb_shift_pipe;

    localparam int N = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  tag;
        logic        ill;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;

    logic [N-1:0]       vld, ordy, irdy, ovld, oill;
    logic [63:0]        dat [N];
    logic [5:0]         sh  [N];
    logic [2:0]         op  [N];
    logic [3:0]         tg  [N];
    logic [N-1:0][63:0] odat;
    logic [N-1:0][3:0]  otg;

    exp_t exp_q [N][$];

    shift_pipe_if #(.WIDTH(32), .TAG_W(4)) bus0 ();
    shift_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus1 ();
    shift_pipe_if #(.WIDTH(64), .TAG_W(4)) bus2 ();
    shift_pipe_if #(.WIDTH(32), .TAG_W(4)) bus3 ();

    shift_pipe #(.WIDTH(32), .PIPE_MASK(8'b0000_0100), .TAG_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    shift_pipe #(.WIDTH(8),  .PIPE_MASK(8'b0000_0111), .TAG_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    shift_pipe #(.WIDTH(64), .PIPE_MASK(8'b0000_0000), .TAG_W(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    shift_pipe #(.WIDTH(32), .PIPE_MASK(8'b0001_1111), .TAG_W(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus0.in_valid = vld[0];  assign bus0.in_data = dat[0][31:0]; assign bus0.in_shamt = sh[0][4:0];
    assign bus0.in_op = op[0];      assign bus0.in_tag = tg[0];         assign bus0.out_ready = ordy[0];
    assign irdy[0] = bus0.in_ready; assign ovld[0] = bus0.out_valid;    assign oill[0] = bus0.out_illegal;
    assign odat[0] = {32'd0, bus0.out_data};                            assign otg[0] = bus0.out_tag;

    assign bus1.in_valid = vld[1];  assign bus1.in_data = dat[1][7:0];  assign bus1.in_shamt = sh[1][2:0];
    assign bus1.in_op = op[1];      assign bus1.in_tag = tg[1];         assign bus1.out_ready = ordy[1];
    assign irdy[1] = bus1.in_ready; assign ovld[1] = bus1.out_valid;    assign oill[1] = bus1.out_illegal;
    assign odat[1] = {56'd0, bus1.out_data};                            assign otg[1] = bus1.out_tag;

    assign bus2.in_valid = vld[2];  assign bus2.in_data = dat[2];       assign bus2.in_shamt = sh[2];
    assign bus2.in_op = op[2];      assign bus2.in_tag = tg[2];         assign bus2.out_ready = ordy[2];
    assign irdy[2] = bus2.in_ready; assign ovld[2] = bus2.out_valid;    assign oill[2] = bus2.out_illegal;
    assign odat[2] = bus2.out_data;                                     assign otg[2] = bus2.out_tag;

    assign bus3.in_valid = vld[3];  assign bus3.in_data = dat[3][31:0]; assign bus3.in_shamt = sh[3][4:0];
    assign bus3.in_op = op[3];      assign bus3.in_tag = tg[3];         assign bus3.out_ready = ordy[3];
    assign irdy[3] = bus3.in_ready; assign ovld[3] = bus3.out_valid;    assign oill[3] = bus3.out_illegal;
    assign odat[3] = {32'd0, bus3.out_data};                            assign otg[3] = bus3.out_tag;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int width_of(input int i);
        case (i)
            1:       return 8;
            2:       return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int mask_of(input int i);
        case (i)
            0:       return 4;
            1:       return 7;
            3:       return 31;
            default: return 0;
        endcase
    endfunction

    // One cycle for the mandatory output register plus one per enabled slice below the last stage.
    function automatic int lat_of(input int i);
        int l;
        l = 1;
        for (int b = 0; b < $clog2(width_of(i)) - 1; b++) l += (mask_of(i) >> b) & 1;
        return l;
    endfunction

    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int s, input logic [2:0] o, input int w);
        logic [127:0] m;
        logic [127:0] x;
        m = (128'd1 << w) - 128'd1;
        x = {64'd0, d} & m;
        case (o)
            3'd0:    return 64'((x << s) & m);
            3'd1:    return 64'(x >> s);
            3'd2:    return 64'(((x | (x[w-1] ? ~m : 128'd0)) >> s) & m);
            3'd3:    return 64'(((x << s) | (x >> (w - s))) & m);
            3'd4:    return 64'(((x >> s) | (x << (w - s))) & m);
            default: return 64'(x);
        endcase
    endfunction

    task automatic drive0(input logic v, input logic [63:0] d, input int s, input logic [2:0] o,
                          input logic [3:0] t, input logic r);
        vld[0] = v; dat[0] = d; sh[0] = 6'(s); op[0] = o; tg[0] = t; ordy[0] = r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0; ordy[i] = 1'b1; dat[i] = '0; sh[i] = '0; op[i] = '0; tg[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (irdy[0] !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", irdy[0]); else n_pass++;
        n_checks++; if (ovld !== 4'b0) $display("FAIL reset_out_valid: got %b want 0000", ovld); else n_pass++;
        n_checks++; if (odat[0] !== 64'd0) $display("FAIL reset_out_data: got %h want 0", odat[0]); else n_pass++;
        n_checks++; if (otg[0] !== 4'd0) $display("FAIL reset_out_tag: got %h want 0", otg[0]); else n_pass++;
        n_checks++; if (oill[0] !== 1'b0) $display("FAIL reset_out_illegal: got %b want 0", oill[0]); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (irdy !== 4'b1111) $display("FAIL release_in_ready: got %b want 1111", irdy); else n_pass++;
    endtask

    task automatic single0(input string name, input logic [31:0] d, input int s, input logic [2:0] o,
                           input logic [31:0] exp_d, input logic exp_ill);
        int         waited;
        logic [3:0] t;
        t = 4'($urandom);
        @(negedge clk);
        drive0(1'b1, {32'd0, d}, s, o, t, 1'b1);
        #1;
        n_checks++; if (irdy[0] !== 1'b1) $display("FAIL %s_accept: in_ready=%b want 1", name, irdy[0]); else n_pass++;
        waited = 0;
        do begin
            @(negedge clk);
            drive0(1'b0, {$urandom, $urandom}, $urandom_range(31), 3'($urandom), 4'($urandom), 1'b1);
            #1;
            waited++;
        end while (!ovld[0] && waited < 10);
        n_checks++; if (waited != 2 || ovld[0] !== 1'b1) $display("FAIL %s_latency: got %0d cycles want 2", name, waited); else n_pass++;
        n_checks++; if (odat[0] !== {32'd0, exp_d}) $display("FAIL %s_data: got %h want %h", name, odat[0], exp_d); else n_pass++;
        n_checks++; if (otg[0] !== t) $display("FAIL %s_tag: got %h want %h", name, otg[0], t); else n_pass++;
        n_checks++; if (oill[0] !== exp_ill) $display("FAIL %s_illegal: got %b want %b", name, oill[0], exp_ill); else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] r;
        single0("sra_ex",  32'h8000_0000, 4, 3'b010, 32'hF800_0000, 1'b0);
        single0("rol_ex",  32'h8000_0001, 1, 3'b011, 32'h0000_0003, 1'b0);
        single0("ror_ex",  32'h8000_0001, 1, 3'b100, 32'hC000_0000, 1'b0);
        single0("ill_ex",  32'h1234_5678, 9, 3'b111, 32'h1234_5678, 1'b1);
        single0("sll_max", 32'h0000_0001, 31, 3'b000, 32'h8000_0000, 1'b0);
        single0("srl_max", 32'h8000_0000, 31, 3'b001, 32'h0000_0001, 1'b0);
        single0("sra_max", 32'h8000_0000, 31, 3'b010, 32'hFFFF_FFFF, 1'b0);
        for (int o = 0; o < 5; o++) begin
            r = $urandom | 32'h8000_0001;
            single0($sformatf("zero_shamt_op%0d", o), r, 0, 3'(o), r, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [8];
        logic [2:0]  o [8];
        int          s [8];
        int          sent, got, t, stalls;
        bit          held, seen;
        logic [63:0] hd;
        logic [3:0]  ht;
        logic        hi;
        for (int k = 0; k < 8; k++) begin
            d[k] = $urandom; o[k] = 3'($urandom_range(4)); s[k] = $urandom_range(31);
        end
        sent = 0; got = 0; t = 0; held = 1'b0; stalls = 0;
        while (got < 8 && t < 40) begin
            @(negedge clk);
            if (sent < 8) drive0(1'b1, {32'd0, d[sent]}, s[sent], o[sent], 4'(sent), !(t >= 4 && t < 7));
            else          drive0(1'b0, {$urandom, $urandom}, 0, 3'd0, 4'd0, !(t >= 4 && t < 7));
            #1;
            if (ovld[0] && !ordy[0]) begin
                if (held) begin
                    stalls++;
                    n_checks++;
                    if (odat[0] !== hd || otg[0] !== ht || oill[0] !== hi)
                        $display("FAIL b2b_stall_stable: got %h/%h/%b want %h/%h/%b", odat[0], otg[0], oill[0], hd, ht, hi);
                    else n_pass++;
                end
                held = 1'b1; hd = odat[0]; ht = otg[0]; hi = oill[0];
            end else begin
                held = 1'b0;
            end
            if (ovld[0] && ordy[0]) begin
                if (got < 8) begin
                    n_checks++; if (otg[0] !== 4'(got)) $display("FAIL b2b_order: got tag %0d want %0d", otg[0], got); else n_pass++;
                    n_checks++;
                    if (odat[0] !== ref_shift({32'd0, d[got]}, s[got], o[got], 32) || oill[0] !== 1'b0)
                        $display("FAIL b2b_data: got %h want %h", odat[0], ref_shift({32'd0, d[got]}, s[got], o[got], 32));
                    else n_pass++;
                end
                got++;
            end
            if (vld[0] && irdy[0]) sent++;
            t++;
        end
        n_checks++; if (got != 8) $display("FAIL b2b_count: got %0d items want 8", got); else n_pass++;
        n_checks++; if (stalls != 2) $display("FAIL b2b_stall_seen: got %0d held cycles want 2", stalls); else n_pass++;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            drive0(1'b0, {$urandom, $urandom}, 0, 3'd0, 4'd0, 1'b1);
            #1;
            if (ovld[0]) seen = 1'b1;
        end
        n_checks++; if (seen) $display("FAIL b2b_no_duplicate: got extra output want none"); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        bit seen;
        @(negedge clk);
        drive0(1'b1, {$urandom, $urandom}, $urandom_range(31), 3'd1, 4'hA, 1'b0);
        @(negedge clk);
        drive0(1'b1, {$urandom, $urandom}, $urandom_range(31), 3'd3, 4'hB, 1'b0);
        @(negedge clk);
        drive0(1'b0, '0, 0, 3'd0, 4'd0, 1'b0);
        #1;
        n_checks++; if (ovld[0] !== 1'b1) $display("FAIL midrst_in_flight: out_valid=%b want 1", ovld[0]); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (ovld[0] !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", ovld[0]); else n_pass++;
        rst = 1'b0;
        ordy[0] = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (ovld[0]) seen = 1'b1;
        end
        n_checks++; if (seen) $display("FAIL midrst_no_emerge: item emerged after reset"); else n_pass++;
    endtask

    task automatic test_random(input bit full_ready, input int pvalid, input int n, input bit exact);
        exp_t e;
        int   w;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                w       = width_of(i);
                vld[i]  = ($urandom_range(99) < pvalid);
                dat[i]  = {$urandom, $urandom};
                sh[i]   = 6'($urandom_range(w - 1));
                op[i]   = 3'($urandom_range(7));
                tg[i]   = 4'($urandom);
                ordy[i] = full_ready ? 1'b1 : ($urandom_range(3) != 0);
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (ovld[i] && ordy[i]) begin
                    n_checks++;
                    if (exp_q[i].size() == 0) begin
                        $display("FAIL rand%0d_spurious: got output tag %h want none", i, otg[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (odat[i] !== e.data || otg[i] !== e.tag || oill[i] !== e.ill)
                            $display("FAIL rand%0d_item: got %h/%h/%b want %h/%h/%b", i, odat[i], otg[i], oill[i], e.data, e.tag, e.ill);
                        else n_pass++;
                        n_checks++;
                        if (exact ? (cyc - e.cyc != lat_of(i)) : (cyc - e.cyc < lat_of(i)))
                            $display("FAIL rand%0d_latency: got %0d want %0d", i, cyc - e.cyc, lat_of(i));
                        else n_pass++;
                    end
                end
                if (vld[i] && irdy[i]) begin
                    e.data = ref_shift(dat[i], int'(sh[i]), op[i], width_of(i));
                    e.tag  = tg[i];
                    e.ill  = (op[i] > 3'd4);
                    e.cyc  = cyc;
                    exp_q[i].push_back(e);
                end
            end
        end
    endtask

    task automatic test_drained();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (exp_q[i].size() != 0) $display("FAIL rand%0d_drain: got %0d pending want 0", i, exp_q[i].size());
            else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random(1'b1, 70, 300, 1'b1);
        test_random(1'b1, 0, 20, 1'b1);
        test_random(1'b0, 60, 400, 1'b0);
        test_random(1'b1, 0, 30, 1'b0);
        test_drained();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter: WIDTH, 32, data width; SHALL be a power of two, 8..64.
REQ-002 Parameter: SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 Parameter: PIPE_MASK, 5'b00100, bit k set = register after log-stage k (stage 0 = largest distance).
REQ-004 Parameter: TAG_W, 4, sideband tag width.
REQ-005 Port: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 Port: rst  in  1  synchronous reset, active-high.
REQ-007 Port: in_valid  in  1; in_ready  out  1: input handshake, transfer when both high.
REQ-008 Port: in_data  in  WIDTH; in_shamt  in  SHAMT_W; in_op  in  3; in_tag  in  TAG_W.
REQ-009 Port: out_valid  out  1; out_ready  in  1: output handshake.
REQ-010 Port: out_data  out  WIDTH; out_tag  out  TAG_W; out_illegal  out  1 (op code unsupported).

Function
REQ-011 in_op encoding SHALL be: 000 SLL, 001 SRL, 010 SRA (fill = in_data[WIDTH-1]), 011 ROL, 100 ROR; 101..111 illegal.
REQ-012 Illegal op SHALL pass in_data unshifted with out_illegal=1; legal ops SHALL give out_illegal=0.
REQ-013 Shift SHALL be log-decomposed: SHAMT_W stages, distances WIDTH/2 down to 1, stage enabled by matching in_shamt bit.
REQ-014 shamt=0 SHALL return in_data unchanged for every op; no shamt overflow exists (SHAMT_W bits cover 0..WIDTH-1).
REQ-015 The final stage output SHALL always be registered; latency = 1 + popcount(PIPE_MASK[SHAMT_W-2:0]) cycles from accepted input to out_valid.
REQ-016 Default latency (WIDTH=32, PIPE_MASK=5'b00100) SHALL be 2 cycles.
REQ-017 op, fill bit, tag SHALL travel with data through every register slice.
REQ-018 Each slice SHALL load when empty or when its downstream slice accepts (bubble collapse); full throughput 1 op/cycle.
REQ-019 in_ready SHALL equal (first slice empty) OR (first slice advancing this cycle); combinational from out_ready permitted.
REQ-020 With out_valid=1 and out_ready=0, out_data/out_tag/out_illegal SHALL hold stable.
REQ-021 Simultaneous accept and emit on a full pipe SHALL lose and duplicate no item; order SHALL be FIFO.
REQ-022 Inputs with in_valid=0 SHALL be ignored regardless of data.

Reset
REQ-023 rst=1 SHALL clear all slice valid bits; out_valid=0, out_data=0, out_tag=0, out_illegal=0 on next edge.
REQ-024 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-025 Reset mid-operation SHALL discard all in-flight items; none emerge after release.

Structure
REQ-026 Op encodings (SHIFT_SLL..SHIFT_ROR) and op typedef SHALL live in shared package shift_pkg.
REQ-027 One sub-module shift_pipe_stage (parameters DIST, REG) SHALL implement one distance stage plus optional slice; shift_pipe SHALL generate SHAMT_W instances.
REQ-028 Rotate SHALL reuse the shift stage with fill taken from wrapped bits; no separate rotate datapath.

Verification
REQ-029 SRA: data=32'h8000_0000, shamt=4, op=010 -> out_data=32'hF800_0000, 2 cycles later.
REQ-030 ROL: data=32'h8000_0001, shamt=1 -> 32'h0000_0003; ROR same inputs -> 32'hC000_0000.
REQ-031 Illegal op=111, data=32'h1234_5678, shamt=9 -> out_data=32'h1234_5678, out_illegal=1.
REQ-032 Back-to-back 8 ops, tags 0..7, out_ready held 0 for 3 cycles mid-stream -> tags emerge 0..7 in order, no loss/duplicate, output stable while stalled.
REQ-033 rst asserted with 2 items in flight -> out_valid=0 next cycle; no item emerges after release.
REQ-034 Random regression at WIDTH=8, 32, 64 and PIPE_MASK=0 and all-ones vs. reference model; latency per REQ-015.
